// File: rtl/pipe_mux.sv
// pipe_mux: registered channel selector with a two-entry skid buffer.
// Each accepted beat captures one channel of in_data (or zero plus an error
// flag for an out-of-range select). The beat is held in a head register that
// drives the outputs and, under backpressure, in a skid register behind it.
// Handshake outputs are decoded from the state register only.
module pipe_mux #(
  parameter int unsigned WIDTH     = 5,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned SEL_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   head_data_q, head_data_d;
  logic               head_err_q, head_err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_err_q, skid_err_d;

  logic [WIDTH-1:0]   beat_data;
  logic               beat_err;
  logic               accept;
  logic               drain;

  // Handshake flags depend on the state register alone.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_data_q;
  assign out_err   = head_err_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Select the addressed channel; an out-of-range select yields zero data.
  always_comb begin
    beat_data = '0;
    beat_err  = (32'(sel) >= CHANNELS);
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (32'(sel) == k) begin
        beat_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and register contents; flush overrides any handshake.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_data_d = beat_data;
          head_err_d  = beat_err;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_data_d = beat_data;
          head_err_d  = beat_err;
        end else if (accept) begin
          state_d     = TWO;
          skid_data_d = beat_data;
          skid_err_d  = beat_err;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d     = ONE;
          head_data_d = skid_data_q;
          head_err_d  = skid_err_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (flush) begin
      state_d     = EMPTY;
      head_data_d = '0;
      head_err_d  = 1'b0;
      skid_data_d = '0;
      skid_err_d  = 1'b0;
    end
  end

  // State and storage registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule
